// File: rtl/ecn_bubble_sorter.sv
// Elementary check node for the EMS non-binary LDPC decoder.
// Merges two sorted (LLR,Q) lists in ascending sum order, dropping repeated Q.
module ecn_bubble_sorter #(
    parameter int LLR_Width = 6,
    parameter int Q_Width   = 5,
    parameter int Depth     = 16,
    parameter int N_OUT     = 16,
    parameter int Cnt_Width = 4
) (
    input  logic                 clk,
    input  logic                 force_reset,
    input  logic                 write_A,
    input  logic [LLR_Width:0]   Input_LLR_A,
    input  logic [Q_Width:0]     Input_Q_A,
    input  logic                 write_I,
    input  logic [LLR_Width:0]   Input_LLR_I,
    input  logic [Q_Width:0]     Input_Q_I,
    output logic                 A_ready,
    output logic                 I_ready,
    input  logic                 receivable,
    output logic                 Output_Valid,
    output logic [LLR_Width:0]   Output_LLR,
    output logic [Q_Width:0]     Output_Q,
    output logic                 Output_Last,
    output logic                 full
);

    localparam int LW = LLR_Width + 1;
    localparam int QW = Q_Width + 1;
    localparam int PW = Cnt_Width + 1;
    localparam int UW = $clog2(N_OUT + 1);
    localparam int NQ = 1 << QW;
    localparam logic [PW-1:0] DEPTH_P = PW'(Depth);
    localparam logic [PW-1:0] DEPTH_M1 = PW'(Depth - 1);
    localparam logic [UW-1:0] NOUT_U = UW'(N_OUT);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [LW-1:0] r_a_llr [Depth];
    logic [QW-1:0] r_a_q   [Depth];
    logic [LW-1:0] r_i_llr [Depth];
    logic [QW-1:0] r_i_q   [Depth];
    logic [PW-1:0] r_ptr   [Depth];

    logic [PW-1:0] r_cnt_a;
    logic [PW-1:0] r_cnt_i;
    logic          r_a_ready;
    logic          r_i_ready;
    logic [NQ-1:0] r_seen;
    logic [UW-1:0] r_uniq;
    logic          r_full;
    logic          r_valid;
    logic [LW-1:0] r_llr;
    logic [QW-1:0] r_q;
    logic          r_last;

    logic [LW:0]          w_sum      [Depth];
    logic [LW-1:0]        w_cand_llr [Depth];
    logic [QW-1:0]        w_cand_q   [Depth];
    logic [Depth-1:0]     w_live;
    logic                 w_sel_ok;
    logic [Cnt_Width-1:0] w_sel_row;
    logic [LW-1:0]        w_sel_llr;
    logic [QW-1:0]        w_sel_q;
    logic                 w_others;
    logic                 w_final;
    logic                 w_a_wr;
    logic                 w_i_wr;
    logic                 w_adv;
    logic                 w_pick;
    logic                 w_load;
    logic                 w_last_in;
    logic [UW-1:0]        w_uniq_nxt;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_dry;
    logic                 w_stall;
    logic                 w_clear;

    // Per-row candidate: A[i] + I[ptr_i], saturated; row live while ptr < Depth
    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            w_live[i] = r_ptr[i] < DEPTH_P;
            w_sum[i] = {1'b0, r_a_llr[i]}
                     + {1'b0, r_i_llr[r_ptr[i][Cnt_Width-1:0]]};
            w_cand_llr[i] = w_sum[i][LW] ? '1 : w_sum[i][LW-1:0];
            w_cand_q[i] = r_a_q[i] ^ r_i_q[r_ptr[i][Cnt_Width-1:0]];
        end
    end

    // Strict less-than keeps the lowest row on ties
    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_row = '0;
        w_sel_llr = '1;
        w_sel_q   = '0;
        w_others  = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (w_live[i] && (!w_sel_ok || w_cand_llr[i] < w_sel_llr)) begin
                w_sel_ok  = 1'b1;
                w_sel_row = Cnt_Width'(i);
                w_sel_llr = w_cand_llr[i];
                w_sel_q   = w_cand_q[i];
            end
        end
        for (int i = 0; i < Depth; i++) begin
            if (w_live[i] && Cnt_Width'(i) != w_sel_row) begin
                w_others = 1'b1;
            end
        end
    end

    assign w_a_wr     = (r_state == LOAD) && write_A && (r_cnt_a != DEPTH_P);
    assign w_i_wr     = (r_state == LOAD) && write_I && (r_cnt_i != DEPTH_P);
    assign w_adv      = (r_state == RUN) && (!r_valid || receivable);
    assign w_pick     = w_adv && w_sel_ok;
    assign w_load     = w_pick && !r_seen[w_sel_q];
    assign w_uniq_nxt = r_uniq + UW'(1);
    assign w_final    = (r_ptr[w_sel_row] == DEPTH_M1) && !w_others;
    assign w_last_in  = (w_uniq_nxt == NOUT_U) || w_final;
    assign w_accept   = r_valid && receivable;
    assign w_done     = w_accept && r_last;
    assign w_dry      = (r_state == RUN) && !w_sel_ok;
    assign w_stall    = r_valid && !receivable;
    assign w_clear    = ((r_state == DRAIN) && w_done)
                      || (w_dry && !w_stall);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LOAD: begin
                if (r_a_ready && r_i_ready) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_load && w_last_in) w_state_nxt = DRAIN;
                else if (w_dry) w_state_nxt = w_stall ? DRAIN : LOAD;
            end
            DRAIN: begin
                if (w_done) w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (force_reset) r_state <= LOAD;
        else             r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_a_wr) begin
            r_a_llr[r_cnt_a[Cnt_Width-1:0]] <= Input_LLR_A;
            r_a_q[r_cnt_a[Cnt_Width-1:0]]   <= Input_Q_A;
        end
        if (w_i_wr) begin
            r_i_llr[r_cnt_i[Cnt_Width-1:0]] <= Input_LLR_I;
            r_i_q[r_cnt_i[Cnt_Width-1:0]]   <= Input_Q_I;
        end
    end

    always_ff @(posedge clk) begin
        if (force_reset || w_clear) begin
            r_cnt_a   <= '0;
            r_cnt_i   <= '0;
            r_a_ready <= 1'b0;
            r_i_ready <= 1'b0;
            for (int i = 0; i < Depth; i++) r_ptr[i] <= '0;
            r_seen    <= '0;
            r_uniq    <= '0;
            r_full    <= 1'b0;
            r_valid   <= 1'b0;
            r_llr     <= '0;
            r_q       <= '0;
            r_last    <= 1'b0;
        end else begin
            if (w_a_wr) begin
                r_cnt_a   <= r_cnt_a + PW'(1);
                r_a_ready <= (r_cnt_a + PW'(1)) == DEPTH_P;
            end
            if (w_i_wr) begin
                r_cnt_i   <= r_cnt_i + PW'(1);
                r_i_ready <= (r_cnt_i + PW'(1)) == DEPTH_P;
            end
            if ((r_state == LOAD) && r_a_ready && r_i_ready) r_full <= 1'b1;
            if (w_pick) r_ptr[w_sel_row] <= r_ptr[w_sel_row] + PW'(1);
            if (w_load) begin
                r_valid         <= 1'b1;
                r_llr           <= w_sel_llr;
                r_q             <= w_sel_q;
                r_last          <= w_last_in;
                r_seen[w_sel_q] <= 1'b1;
                r_uniq          <= w_uniq_nxt;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            // Rows ran out on duplicates: flag the beat still waiting
            if (w_dry && w_stall) r_last <= 1'b1;
        end
    end

    assign A_ready      = r_a_ready;
    assign I_ready      = r_i_ready;
    assign full         = r_full;
    assign Output_Valid = r_valid;
    assign Output_LLR   = r_llr;
    assign Output_Q     = r_q;
    assign Output_Last  = r_last;

endmodule

// File: tb/tb_ecn_bubble_sorter.sv
// Directed bench for ecn_bubble_sorter: Depth=4 with N_OUT=4 and N_OUT=6
// instances fed the same lists; accepted beats are compared to hand values.
module tb_ecn_bubble_sorter;

    logic       clk = 1'b0;
    logic       force_reset;
    logic       write_A, write_I, receivable;
    logic [6:0] in_llr_a, in_llr_i;
    logic [5:0] in_q_a, in_q_i;

    logic       a_rdy [2];
    logic       i_rdy [2];
    logic       vld   [2];
    logic [6:0] llr   [2];
    logic [5:0] q     [2];
    logic       last  [2];
    logic       full  [2];

    int n_vec = 0;
    int n_bad = 0;

    logic [13:0] got4 [$];
    logic [13:0] got6 [$];
    logic [13:0] exp4 [$];
    logic [13:0] exp6 [$];

    logic [6:0] a_llr [6];
    logic [5:0] a_q   [6];
    logic [6:0] i_llr [4];
    logic [5:0] i_q   [4];

    logic [14:0] prev  [2];
    logic        stall [2];
    logic        lacc  [2];

    always #5 clk = ~clk;

    ecn_bubble_sorter #(
        .LLR_Width(6), .Q_Width(5), .Depth(4), .N_OUT(4), .Cnt_Width(2)
    ) u_dut4 (
        .clk(clk), .force_reset(force_reset),
        .write_A(write_A), .Input_LLR_A(in_llr_a), .Input_Q_A(in_q_a),
        .write_I(write_I), .Input_LLR_I(in_llr_i), .Input_Q_I(in_q_i),
        .A_ready(a_rdy[0]), .I_ready(i_rdy[0]), .receivable(receivable),
        .Output_Valid(vld[0]), .Output_LLR(llr[0]), .Output_Q(q[0]),
        .Output_Last(last[0]), .full(full[0])
    );

    ecn_bubble_sorter #(
        .LLR_Width(6), .Q_Width(5), .Depth(4), .N_OUT(6), .Cnt_Width(2)
    ) u_dut6 (
        .clk(clk), .force_reset(force_reset),
        .write_A(write_A), .Input_LLR_A(in_llr_a), .Input_Q_A(in_q_a),
        .write_I(write_I), .Input_LLR_I(in_llr_i), .Input_Q_I(in_q_i),
        .A_ready(a_rdy[1]), .I_ready(i_rdy[1]), .receivable(receivable),
        .Output_Valid(vld[1]), .Output_LLR(llr[1]), .Output_Q(q[1]),
        .Output_Last(last[1]), .full(full[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] m(input logic l, input int v,
                                      input int s);
        return {l, 7'(v), 6'(s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Collect accepted beats, check stalled beats hold, full drops after Last
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (force_reset) begin
                stall[k] = 1'b0;
                lacc[k]  = 1'b0;
            end else begin
                if (stall[k])
                    chk($sformatf("hold%0d", k),
                        {17'd0, vld[k], last[k], llr[k], q[k]},
                        {17'd0, prev[k]});
                if (lacc[k])
                    chk($sformatf("full_drop%0d", k),
                        {30'd0, full[k], vld[k]}, 32'd0);
                if (vld[k] && receivable) begin
                    if (k == 0) got4.push_back({last[k], llr[k], q[k]});
                    else        got6.push_back({last[k], llr[k], q[k]});
                end
                stall[k] = vld[k] && !receivable;
                prev[k]  = {vld[k], last[k], llr[k], q[k]};
                lacc[k]  = vld[k] && receivable && last[k];
            end
        end
    end

    task automatic set_sc1();
        a_llr = '{7'd0, 7'd1, 7'd3, 7'd6, 7'd0, 7'd0};
        a_q   = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd63, 6'd62};
        i_llr = '{7'd0, 7'd2, 7'd2, 7'd5};
        i_q   = '{6'd0, 6'd1, 6'd5, 6'd6};
        exp4 = '{m(0,0,1), m(0,1,2), m(0,2,0), m(1,2,4)};
        exp6 = '{m(0,0,1), m(0,1,2), m(0,2,0), m(0,2,4),
                 m(0,3,3), m(1,3,7)};
    endtask

    task automatic set_sat();
        a_llr = '{7'd100, 7'd110, 7'd120, 7'd127, 7'd0, 7'd0};
        a_q   = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd0, 6'd0};
        i_llr = '{7'd100, 7'd110, 7'd120, 7'd127};
        i_q   = '{6'd0, 6'd4, 6'd8, 6'd12};
        exp4 = '{m(0,127,0), m(0,127,4), m(0,127,8), m(1,127,12)};
        exp6 = '{m(0,127,0), m(0,127,4), m(0,127,8), m(0,127,12),
                 m(0,127,1), m(1,127,5)};
    endtask

    task automatic load(input int na, input string tag);
        got4.delete();
        got6.delete();
        receivable = 1'b1;
        for (int j = 0; j < na; j++) begin
            write_A  = 1'b1;
            in_llr_a = a_llr[j];
            in_q_a   = a_q[j];
            tick();
            if (j == 2) chk({tag, "_a_rdy3"}, a_rdy[0], 1'b0);
            if (j == 3) begin
                chk({tag, "_a_rdy4"}, {a_rdy[0], a_rdy[1]}, 2'b11);
                chk({tag, "_i_rdy0"}, {i_rdy[0], i_rdy[1]}, 2'b00);
            end
        end
        write_A = 1'b0;
        for (int j = 0; j < 4; j++) begin
            write_I  = 1'b1;
            in_llr_i = i_llr[j];
            in_q_i   = i_q[j];
            tick();
        end
        write_I = 1'b0;
        chk({tag, "_rdy"}, {a_rdy[0], i_rdy[0], full[0]}, 3'b110);
        tick();
        chk({tag, "_full"}, {full[0], full[1], vld[0]}, 3'b110);
        tick();
        chk({tag, "_lat"}, {vld[0], vld[1]}, 2'b11);
    endtask

    task automatic run_cmp(input bit bp, input string tag);
        bit done;
        logic [3:0] pat;
        pat  = 4'b1001;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            receivable = bp ? pat[3 - (c % 4)] : 1'b1;
            tick();
            if (!full[0] && !full[1]) done = 1'b1;
        end
        receivable = 1'b1;
        chk({tag, "_finish"}, done, 1'b1);
        chk({tag, "_n4"}, got4.size(), exp4.size());
        chk({tag, "_n6"}, got6.size(), exp6.size());
        for (int j = 0; j < exp4.size(); j++)
            chk($sformatf("%s_b4_%0d", tag, j),
                j < got4.size() ? got4[j] : 14'h3fff, exp4[j]);
        for (int j = 0; j < exp6.size(); j++)
            chk($sformatf("%s_b6_%0d", tag, j),
                j < got6.size() ? got6[j] : 14'h3fff, exp6[j]);
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s%0d", tag, k),
                {vld[k], last[k], llr[k], q[k], full[k], a_rdy[k], i_rdy[k]},
                '0);
    endtask

    initial begin
        force_reset = 1'b1;
        write_A     = 1'b0;
        write_I     = 1'b0;
        receivable  = 1'b1;
        in_llr_a    = '0;
        in_llr_i    = '0;
        in_q_a      = '0;
        in_q_i      = '0;
        for (int k = 0; k < 2; k++) begin
            stall[k] = 1'b0;
            lacc[k]  = 1'b0;
            prev[k]  = '0;
        end
        tick();
        tick();
        chk_idle("rst");
        force_reset = 1'b0;
        tick();

        set_sc1();
        load(6, "ovf");
        run_cmp(1'b0, "sc1");

        tick();
        load(4, "bp");
        run_cmp(1'b1, "bp");

        tick();
        set_sat();
        load(4, "sat");
        run_cmp(1'b0, "sat");

        tick();
        set_sc1();
        load(4, "abt");
        tick();
        tick();
        chk("abt_pre", got4.size(), 2);
        force_reset = 1'b1;
        tick();
        chk_idle("abt");
        force_reset = 1'b0;
        tick();
        load(4, "re");
        run_cmp(1'b0, "re");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
